psg_cmd_queue: RTL
==================

PSG_CMD_QUEUE -- requirements
Module: psg_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: command FIFO depth, power of two, 2..256.
REQ-002 SHALL have parameter GAP, default 2: idle clk cycles forced after each PSG write, 0..15.
REQ-003 SHALL have port clk  in  1: system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port clk_en  in  1: PSG clock-enable strobe, one clk wide; paces WAIT commands only.
REQ-006 SHALL have port flush  in  1: synchronous discard of all queued and in-progress commands.
REQ-007 SHALL have port cmd_valid  in  1: host command present.
REQ-008 SHALL have port cmd_ready  out  1: queue accepts command this cycle.
REQ-009 SHALL have port cmd_wait  in  1: 1 = delay command, 0 = register write.
REQ-010 SHALL have port cmd_addr  in  4: PSG register address (ignored when cmd_wait=1).
REQ-011 SHALL have port cmd_data  in  8: register data, or delay count in clk_en strobes when cmd_wait=1.
REQ-012 SHALL have port psg_addr  out  4: address to PSG.
REQ-013 SHALL have port psg_din  out  8: write data to PSG.
REQ-014 SHALL have port psg_wr_n  out  1: active-low PSG write strobe.
REQ-015 SHALL have port psg_cs_n  out  1: active-low PSG chip select, equal to psg_wr_n.
REQ-016 SHALL have port level  out  clog2(DEPTH)+1: current FIFO occupancy.
REQ-017 SHALL have port busy  out  1: high when level!=0 or FSM not IDLE.

Function
REQ-018 SHALL store entries {wait, addr[3:0], data[7:0]} in a DEPTH-entry FIFO with wrapping read/write pointers.
REQ-019 SHALL drive cmd_ready = (level<DEPTH) && !flush, combinationally.
REQ-020 SHALL push on cmd_valid && cmd_ready; at full no push occurs even if a pop happens the same cycle.
REQ-021 SHALL update level by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL implement FSM states IDLE, WRITE, GAP, WAIT.
REQ-023 IDLE: if level!=0, pop head; wait=0 -> WRITE; wait=1 with data=0 -> stay IDLE (no-op); wait=1 with data>0 -> WAIT, counter=data.
REQ-024 WRITE: lasts exactly one clk; psg_wr_n=psg_cs_n=0, psg_addr/psg_din = popped entry; next GAP if GAP>0, else IDLE.
REQ-025 GAP: psg_wr_n=1 for exactly GAP clk cycles, then IDLE.
REQ-026 WAIT: decrement counter on each clk_en; on the strobe taking it to 0 go IDLE next cycle; non-strobe cycles hold.
REQ-027 SHALL register all PSG outputs; psg_addr/psg_din hold last written values outside WRITE.
REQ-028 Latency: command pushed into an empty idle queue in cycle n SHALL give psg_wr_n=0 in cycle n+2.
REQ-029 Back-to-back writes SHALL be spaced exactly GAP+2 cycles apart in psg_wr_n low pulses (WRITE, GAP cycles, IDLE pop).
REQ-030 flush SHALL, next cycle: empty FIFO (level=0), FSM IDLE, psg_wr_n=psg_cs_n=1; a push in the flush cycle is refused; flush during WRITE cuts no already-issued strobe but prevents further writes.
REQ-031 flush SHALL NOT alter psg_addr/psg_din.
REQ-032 FIFO data SHALL NOT be corrupted by pointer wrap; order strictly first-in first-out.

Reset
REQ-033 On reset: level=0, pointers=0, FSM IDLE, WAIT counter=0, psg_wr_n=1, psg_cs_n=1, psg_addr=0, psg_din=0, busy=0.
REQ-034 cmd_ready SHALL be 0 during reset cycles and 1 the first cycle after reset deasserts.
REQ-035 Reset mid-WAIT or mid-GAP SHALL abort the operation with no further PSG write.

Verification
REQ-036 Push 8 writes addr {11,12,0,1,8,6,13,7} data {120,0,40,0,48,1,14,8} on consecutive cycles, GAP=2 -> 8 one-cycle psg_wr_n pulses, 4 cycles apart, same order/values; first pulse 2 cycles after first push.
REQ-037 Write(0,40), WAIT data=3, write(1,0), clk_en every 4th clk -> second write only after 3 clk_en strobes counted after WAIT entry; WAIT data=0 adds no delay.
REQ-038 Hold cmd_valid with PSG writes stalled by long WAIT, DEPTH=16 -> cmd_ready falls at level=16; simultaneous pop at full accepts no push; level never exceeds 16; entries emerge in order across pointer wrap.
REQ-039 Flush asserted with level=5 during GAP while cmd_valid=1 -> next cycle level=0, busy=0, no further psg_wr_n pulse, flush-cycle push refused.
REQ-040 Reset asserted during WAIT with level=3 -> next cycle all REQ-033 values; no write issued afterward until new push.
REQ-041 GAP=0 -> consecutive writes produce psg_wr_n low pulses exactly 2 cycles apart.

Source files
------------

// File: rtl/psg_cmd_queue.sv
`default_nettype none
//==============================================================================
// psg_cmd_queue - FIFO of PSG register writes and clk_en-paced delays, replayed
//                 as one-cycle write strobes followed by a fixed idle gap.
// Revision: 1.0
//==============================================================================
module psg_cmd_queue #(
   parameter int DEPTH = 16,
   parameter int GAP   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_en,
   input  logic                    flush,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_wait,
   input  logic [3:0]              cmd_addr,
   input  logic [7:0]              cmd_data,
   output logic [3:0]              psg_addr,
   output logic [7:0]              psg_din,
   output logic                    psg_wr_n,
   output logic                    psg_cs_n,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL     = LW'(DEPTH);
   localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_GAP   = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [12:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [7:0]    wait_cnt, wait_nx;
   logic [3:0]    gap_cnt, gap_nx;
   logic          push, pop;
   logic          head_wait;
   logic [3:0]    head_addr;
   logic [7:0]    head_data;

   assign {head_wait, head_addr, head_data} = mem[rd_ptr];

   // Reset is folded in so the host sees the queue as unavailable while held.
   assign cmd_ready = (level < FULL) && !flush && !reset;
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (level != '0) || (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_wait, cmd_addr, cmd_data};
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         gap_cnt  <= gap_nx;
      end
   end

   always_comb begin
      state_nx = state;
      wait_nx  = wait_cnt;
      gap_nx   = gap_cnt;
      pop      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (level != '0) begin
               pop = 1'b1;
               if (!head_wait) begin
                  state_nx = ST_WRITE;
               end else if (head_data != 8'd0) begin
                  state_nx = ST_WAIT;
                  wait_nx  = head_data;
               end
            end
         end
         ST_WRITE: begin
            if (GAP > 0) begin
               state_nx = ST_GAP;
               gap_nx   = GAP_LAST;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt == 4'd0) begin
               state_nx = ST_IDLE;
            end else begin
               gap_nx = gap_cnt - 4'd1;
            end
         end
         ST_WAIT: begin
            if (clk_en) begin
               wait_nx = wait_cnt - 8'd1;
               if (wait_cnt == 8'd1) state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      // A strobe already on the pins completes; nothing further is issued.
      if (flush) begin
         state_nx = ST_IDLE;
         wait_nx  = '0;
         gap_nx   = '0;
         pop      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         psg_wr_n <= 1'b1;
         psg_cs_n <= 1'b1;
         psg_addr <= '0;
         psg_din  <= '0;
      end else begin
         psg_wr_n <= (state_nx != ST_WRITE);
         psg_cs_n <= (state_nx != ST_WRITE);
         if (pop && !head_wait) begin
            psg_addr <= head_addr;
            psg_din  <= head_data;
         end
      end
   end

endmodule
`default_nettype wire
